// File: rtl/bf_sched_pkg.sv
// Shared state encoding and default frame geometry for the beamformer scan scheduler.
// The ERROR state is present only when BF_SCHED_TIMEOUT_EN is defined.
package bf_sched_pkg;

  localparam int DEBUG_W = 3;

  typedef enum logic [DEBUG_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_BF = 3'd2,
    ST_OUTPUT  = 3'd3
`ifdef BF_SCHED_TIMEOUT_EN
    ,ST_ERROR  = 3'd4
`endif
  } state_e;

  localparam int          DEF_X_POINTS  = 64;
  localparam int          DEF_Z_POINTS  = 256;
  localparam logic [15:0] DEF_X_START   = 16'h0000;
  localparam logic [15:0] DEF_X_STEP    = 16'h0010;
  localparam logic [15:0] DEF_Z_START   = 16'h0040;
  localparam logic [15:0] DEF_Z_STEP    = 16'h0004;
  localparam int          DEF_SUM_WIDTH = 20;
  localparam int          DEF_TIMEOUT   = 1023;

  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bf_point_counter.sv
// Focal-grid walker: z inner, x outer, with incremental 16-bit coordinates that wrap modulo 2^16.
module bf_point_counter
  import bf_sched_pkg::*;
#(
  parameter int          X_POINTS = DEF_X_POINTS,
  parameter int          Z_POINTS = DEF_Z_POINTS,
  parameter logic [15:0] X_START  = DEF_X_START,
  parameter logic [15:0] X_STEP   = DEF_X_STEP,
  parameter logic [15:0] Z_START  = DEF_Z_START,
  parameter logic [15:0] Z_STEP   = DEF_Z_STEP,
  parameter int          XW       = idx_w(X_POINTS),
  parameter int          ZW       = idx_w(Z_POINTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          advance_i,
  output logic [XW-1:0] x_idx_o,
  output logic [ZW-1:0] z_idx_o,
  output logic [15:0]   x_f_o,
  output logic [15:0]   z_f_o,
  output logic          line_last_o,
  output logic          frame_last_o
);

  logic [XW-1:0] x_idx_q, x_idx_d;
  logic [ZW-1:0] z_idx_q, z_idx_d;
  logic [15:0]   x_f_q, x_f_d;
  logic [15:0]   z_f_q, z_f_d;

  assign line_last_o  = (z_idx_q == ZW'(Z_POINTS - 1));
  assign frame_last_o = line_last_o && (x_idx_q == XW'(X_POINTS - 1));

  always_comb begin
    x_idx_d = x_idx_q;
    z_idx_d = z_idx_q;
    x_f_d   = x_f_q;
    z_f_d   = z_f_q;
    if (load_i) begin
      x_idx_d = '0;
      z_idx_d = '0;
      x_f_d   = X_START;
      z_f_d   = Z_START;
    end else if (advance_i) begin
      if (line_last_o) begin
        z_idx_d = '0;
        z_f_d   = Z_START;
        x_idx_d = x_idx_q + XW'(1);
        x_f_d   = x_f_q + X_STEP;
      end else begin
        z_idx_d = z_idx_q + ZW'(1);
        z_f_d   = z_f_q + Z_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_idx_q <= '0;
      z_idx_q <= '0;
      x_f_q   <= X_START;
      z_f_q   <= Z_START;
    end else begin
      x_idx_q <= x_idx_d;
      z_idx_q <= z_idx_d;
      x_f_q   <= x_f_d;
      z_f_q   <= z_f_d;
    end
  end

  assign x_idx_o = x_idx_q;
  assign z_idx_o = z_idx_q;
  assign x_f_o   = x_f_q;
  assign z_f_o   = z_f_q;

endmodule

// File: rtl/bf_scan_scheduler.sv
// Frame sequencer: one beamformer run per focal point, results streamed out with grid tags.
// Define BF_SCHED_TIMEOUT_EN to add the WAIT_BF watchdog and the sticky ERROR state.
module bf_scan_scheduler
  import bf_sched_pkg::*;
#(
  parameter int          X_POINTS  = DEF_X_POINTS,
  parameter int          Z_POINTS  = DEF_Z_POINTS,
  parameter logic [15:0] X_START   = DEF_X_START,
  parameter logic [15:0] X_STEP    = DEF_X_STEP,
  parameter logic [15:0] Z_START   = DEF_Z_START,
  parameter logic [15:0] Z_STEP    = DEF_Z_STEP,
  parameter int          SUM_WIDTH = DEF_SUM_WIDTH,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scan_start,
  input  logic                          scan_abort,
  output logic                          bf_start,
  output logic [15:0]                   bf_x_f,
  output logic [15:0]                   bf_z_f,
  input  logic                          bf_done,
  input  logic [SUM_WIDTH-1:0]          bf_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SUM_WIDTH-1:0]          out_data,
  output logic [idx_w(X_POINTS)-1:0]    out_x_idx,
  output logic [idx_w(Z_POINTS)-1:0]    out_z_idx,
  output logic                          out_line_end,
  output logic                          out_frame_end,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error,
  output logic [DEBUG_W-1:0]            debug_state
);

  localparam int XW = idx_w(X_POINTS);
  localparam int ZW = idx_w(Z_POINTS);

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] out_data_q, out_data_d;
  logic                 line_end_q, line_end_d;
  logic                 frame_end_q, frame_end_d;
  logic                 frame_done_q, frame_done_d;
  logic                 error_q, error_d;
  logic                 ctr_load, ctr_adv;
  logic                 line_last, frame_last;

`ifdef BF_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  bf_point_counter #(
    .X_POINTS(X_POINTS), .Z_POINTS(Z_POINTS),
    .X_START(X_START), .X_STEP(X_STEP),
    .Z_START(Z_START), .Z_STEP(Z_STEP),
    .XW(XW), .ZW(ZW)
  ) u_point_counter (
    .clk(clk), .reset(reset),
    .load_i(ctr_load), .advance_i(ctr_adv),
    .x_idx_o(out_x_idx), .z_idx_o(out_z_idx),
    .x_f_o(bf_x_f), .z_f_o(bf_z_f),
    .line_last_o(line_last), .frame_last_o(frame_last)
  );

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    line_end_d   = line_end_q;
    frame_end_d  = frame_end_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    ctr_load     = 1'b0;
    ctr_adv      = 1'b0;
`ifdef BF_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          state_d  = ST_ISSUE;
          ctr_load = 1'b1;
          error_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BF;
`ifdef BF_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT_BF: begin
        if (bf_done) begin
          state_d     = ST_OUTPUT;
          out_data_d  = bf_result;
          line_end_d  = line_last;
          frame_end_d = frame_last;
        end
`ifdef BF_SCHED_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          line_end_d  = 1'b0;
          frame_end_d = 1'b0;
          if (frame_end_q) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            ctr_adv = 1'b1;
          end
        end
      end
`ifdef BF_SCHED_TIMEOUT_EN
      ST_ERROR: state_d = ST_ERROR;
`endif
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any capture or handshake decided above.
    if (scan_abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      out_data_d   = out_data_q;
      line_end_d   = 1'b0;
      frame_end_d  = 1'b0;
      frame_done_d = 1'b0;
      ctr_adv      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      out_data_q   <= '0;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef BF_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      line_end_q   <= line_end_d;
      frame_end_q  <= frame_end_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
`ifdef BF_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bf_start      = (state_q == ST_ISSUE);
  assign out_valid     = (state_q == ST_OUTPUT);
  assign out_data      = out_data_q;
  assign out_line_end  = line_end_q;
  assign out_frame_end = frame_end_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = frame_done_q;
  assign debug_state   = state_q;
`ifdef BF_SCHED_TIMEOUT_EN
  assign error         = error_q;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_bf_scan_scheduler.sv
// Directed bench for bf_scan_scheduler on a 2x3 grid; a second instance exercises z coordinate wrap.
module tb_bf_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_start = 1'b0;
  logic        scan_abort = 1'b0;
  logic        bf_done = 1'b0;
  logic [19:0] bf_result = '0;
  logic        out_ready = 1'b0;

  logic        bf_start, out_valid, out_line_end, out_frame_end, busy, frame_done, error;
  logic [15:0] bf_x_f, bf_z_f;
  logic [19:0] out_data;
  logic [1:0]  out_x_idx;
  logic [2:0]  out_z_idx;
  logic [2:0]  debug_state;

  logic        w_bf_start, w_out_valid, w_out_line_end, w_out_frame_end, w_busy, w_frame_done, w_error;
  logic [15:0] w_bf_x_f, w_bf_z_f;
  logic [19:0] w_out_data;
  logic [1:0]  w_out_x_idx;
  logic [2:0]  w_out_z_idx;
  logic [2:0]  w_debug_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bf_scan_scheduler #(
    .X_POINTS(2), .Z_POINTS(3), .SUM_WIDTH(20), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start), .scan_abort(scan_abort),
    .bf_start(bf_start), .bf_x_f(bf_x_f), .bf_z_f(bf_z_f),
    .bf_done(bf_done), .bf_result(bf_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x_idx(out_x_idx), .out_z_idx(out_z_idx),
    .out_line_end(out_line_end), .out_frame_end(out_frame_end),
    .busy(busy), .frame_done(frame_done), .error(error), .debug_state(debug_state)
  );

  bf_scan_scheduler #(
    .X_POINTS(2), .Z_POINTS(3), .Z_START(16'hFFFC), .Z_STEP(16'h0004),
    .SUM_WIDTH(20), .TIMEOUT(20)
  ) dut_w (
    .clk(clk), .reset(reset), .scan_start(scan_start), .scan_abort(scan_abort),
    .bf_start(w_bf_start), .bf_x_f(w_bf_x_f), .bf_z_f(w_bf_z_f),
    .bf_done(bf_done), .bf_result(bf_result),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_x_idx(w_out_x_idx), .out_z_idx(w_out_z_idx),
    .out_line_end(w_out_line_end), .out_frame_end(w_out_frame_end),
    .busy(w_busy), .frame_done(w_frame_done), .error(w_error), .debug_state(w_debug_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns in the cycle out_valid is expected.
  task automatic finish_bf(input logic [19:0] res);
    repeat (5) step();
    bf_done   = 1'b1;
    bf_result = res;
    step();
    bf_done   = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bf_start !== 1'b0) begin n_bad++; $display("FAIL reset_bf_start: got %b want 0", bf_start); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if ({out_line_end, out_frame_end} !== 2'b00) begin n_bad++; $display("FAIL reset_end_flags: got %b want 00", {out_line_end, out_frame_end}); end
    n_cmp++; if (out_data !== 20'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if ({out_x_idx, out_z_idx} !== 5'h0) begin n_bad++; $display("FAIL reset_idx: got %h want 0", {out_x_idx, out_z_idx}); end
    n_cmp++; if (bf_x_f !== 16'h0000) begin n_bad++; $display("FAIL reset_bf_x_f: got %h want 0000", bf_x_f); end
    n_cmp++; if (bf_z_f !== 16'h0040) begin n_bad++; $display("FAIL reset_bf_z_f: got %h want 0040", bf_z_f); end
    n_cmp++; if (debug_state !== 3'd0) begin n_bad++; $display("FAIL reset_debug_state: got %0d want 0", debug_state); end
    n_cmp++; if (w_bf_z_f !== 16'hFFFC) begin n_bad++; $display("FAIL reset_wrap_z_f: got %h want fffc", w_bf_z_f); end
  endtask

  task automatic test_idle_done();
    bf_done = 1'b1;
    bf_result = 20'h12345;
    step();
    bf_done = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || debug_state !== 3'd0) begin n_bad++; $display("FAIL idle_done_ignored: valid %b state %0d want 0/0", out_valid, debug_state); end
    n_cmp++; if (out_data !== 20'h0) begin n_bad++; $display("FAIL idle_done_data: got %h want 0", out_data); end
  endtask

  task automatic test_full_frame();
    logic [15:0] exp_xf, exp_zf;
    logic [19:0] exp_d;
    int ex, ez;
    out_ready = 1'b1;
    pulse_start();
    for (int p = 0; p < 6; p++) begin
      ex = p / 3;
      ez = p % 3;
      exp_xf = (ex == 1) ? 16'h0010 : 16'h0000;
      exp_zf = 16'h0040 + 16'(4 * ez);
      exp_d  = 20'h0A000 + 20'(p);
      n_cmp++; if (bf_start !== 1'b1) begin n_bad++; $display("FAIL frame_bf_start p%0d: got %b want 1", p, bf_start); end
      n_cmp++; if (bf_x_f !== exp_xf) begin n_bad++; $display("FAIL frame_bf_x_f p%0d: got %h want %h", p, bf_x_f, exp_xf); end
      n_cmp++; if (bf_z_f !== exp_zf) begin n_bad++; $display("FAIL frame_bf_z_f p%0d: got %h want %h", p, bf_z_f, exp_zf); end
      if (p < 2) begin
        n_cmp++; if (w_bf_z_f !== ((p == 0) ? 16'hFFFC : 16'h0000)) begin n_bad++; $display("FAIL wrap_z_f p%0d: got %h", p, w_bf_z_f); end
      end
      finish_bf(exp_d);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL frame_out_valid p%0d: got %b want 1", p, out_valid); end
      n_cmp++; if (out_data !== exp_d) begin n_bad++; $display("FAIL frame_out_data p%0d: got %h want %h", p, out_data, exp_d); end
      n_cmp++; if (out_x_idx !== 2'(ex) || out_z_idx !== 3'(ez)) begin n_bad++; $display("FAIL frame_idx p%0d: got (%0d,%0d) want (%0d,%0d)", p, out_x_idx, out_z_idx, ex, ez); end
      n_cmp++; if (out_line_end !== (ez == 2)) begin n_bad++; $display("FAIL frame_line_end p%0d: got %b", p, out_line_end); end
      n_cmp++; if (out_frame_end !== (p == 5)) begin n_bad++; $display("FAIL frame_frame_end p%0d: got %b", p, out_frame_end); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_early p%0d: got %b want 0", p, frame_done); end
      step();
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_idle: busy %b valid %b want 0/0", busy, out_valid); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pulse_start();
    step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    n_cmp++; if (debug_state !== 3'd2 || bf_start !== 1'b0) begin n_bad++; $display("FAIL start_while_busy: state %0d bf_start %b want 2/0", debug_state, bf_start); end
    finish_bf(20'h5A5A5);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || bf_start !== 1'b0 || out_data !== 20'h5A5A5 || out_x_idx !== 2'd0 || out_z_idx !== 3'd0) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: valid %b bf_start %b data %h idx (%0d,%0d) want 1/0/5a5a5/(0,0)", i, out_valid, bf_start, out_data, out_x_idx, out_z_idx);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (bf_start !== 1'b1 || bf_z_f !== 16'h0044) begin n_bad++; $display("FAIL bp_release: bf_start %b z_f %h want 1/0044", bf_start, bf_z_f); end
  endtask

  task automatic test_abort();
    step();
    step();
    bf_done    = 1'b1;
    bf_result  = 20'hFFFFF;
    scan_abort = 1'b1;
    step();
    bf_done    = 1'b0;
    scan_abort = 1'b0;
    n_cmp++; if (debug_state !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: state %0d busy %b want 0/0", debug_state, busy); end
    n_cmp++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL abort_outputs: valid %b frame_done %b want 0/0", out_valid, frame_done); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL abort_after: valid %b frame_done %b want 0/0", out_valid, frame_done); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    pulse_start();
    finish_bf(20'h11111);
    step();
    out_ready = 1'b0;
    finish_bf(20'h22222);
    n_cmp++; if (out_valid !== 1'b1 || out_z_idx !== 3'd1 || bf_z_f !== 16'h0044) begin n_bad++; $display("FAIL rst_pre: valid %b z %0d z_f %h want 1/1/0044", out_valid, out_z_idx, bf_z_f); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || debug_state !== 3'd0) begin n_bad++; $display("FAIL rst_async_ctrl: valid %b busy %b state %0d want 0/0/0", out_valid, busy, debug_state); end
    n_cmp++; if (out_data !== 20'h0 || out_z_idx !== 3'd0 || bf_z_f !== 16'h0040) begin n_bad++; $display("FAIL rst_async_data: data %h z %0d z_f %h want 0/0/0040", out_data, out_z_idx, bf_z_f); end
    step();
    reset = 1'b1;
    step();
    pulse_start();
    n_cmp++; if (bf_start !== 1'b1 || bf_x_f !== 16'h0000 || bf_z_f !== 16'h0040) begin n_bad++; $display("FAIL rst_restart: bf_start %b x_f %h z_f %h want 1/0000/0040", bf_start, bf_x_f, bf_z_f); end
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
  endtask

`ifdef BF_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    repeat (20) step();
    n_cmp++; if (debug_state !== 3'd2 || error !== 1'b0) begin n_bad++; $display("FAIL to_before: state %0d error %b want 2/0", debug_state, error); end
    step();
    n_cmp++; if (debug_state !== 3'd4 || error !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL to_error: state %0d error %b busy %b want 4/1/1", debug_state, error, busy); end
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
    n_cmp++; if (debug_state !== 3'd0 || error !== 1'b1) begin n_bad++; $display("FAIL to_abort: state %0d error %b want 0/1", debug_state, error); end
    pulse_start();
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL to_clear: error %b want 0", error); end
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) step();
    test_reset();
    reset = 1'b1;
    step();
    test_idle_done();
    test_full_frame();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef BF_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf_scan_scheduler.md
# bf_scan_scheduler

Sequences the delay-and-sum beamformer across a full image frame. Walks a rectangular grid of focal points, z inner and x outer, and drives one beamformer run per point with `bf_x_f`/`bf_z_f`/`bf_start`. Captures each summed result and hands it to the envelope-detection stage over a valid/ready stream tagged with grid indices.

## Interface
- `X_POINTS`, 64: lateral focal points per frame, ≥1
- `Z_POINTS`, 256: axial focal points per scan line, ≥1
- `X_START`, 16'h0000: first lateral focal coordinate (same units as beamformer `x_f`)
- `X_STEP`, 16'h0010: lateral increment
- `Z_START`, 16'h0040: first axial coordinate
- `Z_STEP`, 16'h0004: axial increment
- `SUM_WIDTH`, 20: beamformer result width
- `TIMEOUT`, 1023: watchdog limit in cycles (used only with `BF_SCHED_TIMEOUT_EN`)
- `clk` in 1: the single clock; all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `scan_start` in 1: starts a frame; sampled only in IDLE
- `scan_abort` in 1: terminates the frame
- `bf_start` out 1: one-cycle pulse launching a beamformer run
- `bf_x_f` out 16: lateral focal coordinate for the current point
- `bf_z_f` out 16: axial focal coordinate for the current point
- `bf_done` in 1: one-cycle pulse; `bf_result` is valid in the same cycle
- `bf_result` in SUM_WIDTH: beamformed sample
- `out_valid` out 1: output sample available
- `out_ready` in 1: downstream accepts the sample
- `out_data` out SUM_WIDTH: captured sample
- `out_x_idx` out clog2(X_POINTS)+1: lateral index of the sample
- `out_z_idx` out clog2(Z_POINTS)+1: axial index of the sample
- `out_line_end` out 1: sample is the last point of its scan line
- `out_frame_end` out 1: sample is the last point of the frame
- `busy` out 1: high in every state except IDLE
- `frame_done` out 1: one-cycle pulse after the final sample is accepted
- `error` out 1: sticky watchdog flag
- `debug_state` out 3: current FSM state encoding

## Operation
- States:
  - IDLE=0, ISSUE=1, WAIT_BF=2, OUTPUT=3.
  - ERROR=4 exists only with the macro.
- IDLE → ISSUE on `scan_start`.
  - The transition clears x/z indices.
  - It also loads `bf_x_f`=X_START and `bf_z_f`=Z_START.
- ISSUE: `bf_start`=1 for exactly this cycle; next state is WAIT_BF.
- WAIT_BF: on `bf_done`, register `bf_result` into `out_data`, set `out_valid`, and go to OUTPUT.
  - `bf_done` in any other state is ignored.
- OUTPUT: hold `out_valid`, `out_data`, indices and end flags stable until `out_ready`.
- On the OUTPUT handshake:
  - Frame end: pulse `frame_done` and go to IDLE.
  - Otherwise advance the indices and go to ISSUE.
- Index advance:
  - z increments and `bf_z_f` += Z_STEP.
  - At z=Z_POINTS-1: z wraps to 0, `bf_z_f` reloads Z_START, x increments and `bf_x_f` += X_STEP.
- Coordinate arithmetic is incremental 16-bit unsigned with modulo-2^16 wrap; there is no saturation.
- `bf_x_f`/`bf_z_f` change only on handshake or frame load. They are stable from ISSUE through WAIT_BF.
- `scan_abort` in any non-IDLE state:
  - Next state is IDLE, `out_valid` drops, and `frame_done` is not pulsed.
  - Abort wins over a simultaneous `bf_done` or handshake.
- `scan_start` while `busy` is ignored.
- `reset` asserted mid-frame: immediate return to IDLE, and all outputs take their reset values.

## Timing
- Reset values:
  - `bf_start`, `out_valid`, `busy`, `frame_done`, `error`, `out_line_end`, `out_frame_end` = 0.
  - `out_data` and indices = 0.
  - `bf_x_f`=X_START, `bf_z_f`=Z_START, `debug_state`=0.
- `scan_start` at cycle T → `bf_start` at T+1.
- `bf_done` at cycle D → `out_valid` at D+1.
- Handshake at cycle H → next `bf_start` at H+1, carrying the new coordinates.
- Minimum cost per point is beamformer latency + 2 cycles, with zero backpressure.
- `out_line_end`/`out_frame_end` are registered together with `out_valid`.
- `frame_done` is asserted at H+1 and `busy` is low from H+1.

## Configuration
- `BF_SCHED_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT_BF. Reaching TIMEOUT without `bf_done` sets `error` and enters ERROR.
  - ERROR holds with `busy`=1. It leaves only via `scan_abort` (→ IDLE, `error` stays set) or `reset`.
  - `error` clears on the next accepted `scan_start`.
- Undefined: no counter and no ERROR state; `error` is tied to 0, and WAIT_BF waits indefinitely.

## Structure
- Package `bf_sched_pkg`: state encoding constants, debug width (3), default grid and step constants.
- Sub-module `bf_point_counter`: x/z index counters, incremental coordinate generation, and line-end/frame-end flags. Controls are load/advance; it is instantiated once.

## Test plan
- Full frame, X_POINTS=2, Z_POINTS=3, model latency 5, `out_ready`=1 → 6 samples in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2):
  - `bf_z_f` 0x40,0x44,0x48; `bf_x_f` 0x00 then 0x10.
  - `out_line_end` on z=2; `out_frame_end` and then `frame_done` on the 6th.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_data`/indices stable, no `bf_start`; release → next `bf_start` one cycle later.
- Abort in WAIT_BF coinciding with `bf_done` → IDLE next cycle, `out_valid`=0, no `frame_done`.
- Coordinate wrap: Z_START=16'hFFFC, Z_STEP=4 → second point `bf_z_f`=16'h0000.
- Reset deasserted→asserted mid-OUTPUT → all outputs at reset values asynchronously; a new `scan_start` restarts from (0,0).
- With `BF_SCHED_TIMEOUT_EN`, TIMEOUT=20, no `bf_done` → `error`=1 after 20 cycles in WAIT_BF and `debug_state`=4; `scan_abort` → IDLE.
